// File: rtl/hy_loader_pkg.sv
// Shared definitions for the H/Y ping-pong loader: calc FSM encoding,
// bank count and an index-width helper.
package hy_loader_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_START   = 2'd1,
        C_WAIT    = 2'd2,
        C_RELEASE = 2'd3
    } calc_state_t;

    // Width of an index counting 0..n-1; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hy_bank_mem.sv
// One H/Y storage bank: write counters, done/full flags, conjugating Y write
// path with saturation, and combinational read mux.
module hy_bank_mem
    import hy_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int NR    = 4,
    parameter int NT    = 4,
    parameter int NSLOT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h_we,
    input  logic [N-1:0]              h_wr_r,
    input  logic [N-1:0]              h_wr_i,
    input  logic                      y_we,
    input  logic [N-1:0]              y_wr_r,
    input  logic [N-1:0]              y_wr_i,
    input  logic                      rel,
    input  logic [idx_w(NR)-1:0]      rd_h_row,
    input  logic [idx_w(NT)-1:0]      rd_h_col,
    input  logic [idx_w(NR)-1:0]      rd_y_idx,
    input  logic [idx_w(NSLOT)-1:0]   rd_y_slot,
    output logic [N-1:0]              rd_h_r,
    output logic [N-1:0]              rd_h_i,
    output logic [N-1:0]              rd_y_r,
    output logic [N-1:0]              rd_y_i,
    output logic                      h_done,
    output logic                      y_done,
    output logic                      full,
    output logic                      complete
);

    localparam int HD = NR * NT;
    localparam int YD = NR * NSLOT;
    localparam int HW = idx_w(HD);
    localparam int YW = idx_w(YD);
    localparam logic [HW-1:0] H_LAST = HW'(HD - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(YD - 1);
    localparam logic [N-1:0]  S_MIN  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  S_MAX  = {1'b0, {(N-1){1'b1}}};

    logic [N-1:0] h_r_mem [HD];
    logic [N-1:0] h_i_mem [HD];
    logic [N-1:0] y_r_mem [YD];
    logic [N-1:0] y_i_mem [YD];

    logic [HW-1:0] h_cnt;
    logic [YW-1:0] y_cnt;
    logic          h_last;
    logic          y_last;
    logic [N-1:0]  y_conj_i;
    logic [HW-1:0] h_rd_addr;
    logic [YW-1:0] y_rd_addr;

    assign h_last   = h_we && (h_cnt == H_LAST);
    assign y_last   = y_we && (y_cnt == Y_LAST);
    assign full     = h_done && y_done;
    assign complete = !full && (h_done || h_last) && (y_done || y_last);

    // Negating the most negative value would overflow, so it clamps to max.
    assign y_conj_i = (y_wr_i == S_MIN) ? S_MAX : -y_wr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt  <= '0;
            y_cnt  <= '0;
            h_done <= 1'b0;
            y_done <= 1'b0;
        end else if (rel) begin
            h_cnt  <= '0;
            y_cnt  <= '0;
            h_done <= 1'b0;
            y_done <= 1'b0;
        end else begin
            if (h_we) begin
                if (h_last) begin
                    h_cnt  <= '0;
                    h_done <= 1'b1;
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
            if (y_we) begin
                if (y_last) begin
                    y_cnt  <= '0;
                    y_done <= 1'b1;
                end else begin
                    y_cnt <= y_cnt + YW'(1);
                end
            end
        end
    end

    // Storage is not reset; the done flags alone say whether it is valid.
    always_ff @(posedge clk) begin
        if (h_we) begin
            h_r_mem[h_cnt] <= h_wr_r;
            h_i_mem[h_cnt] <= h_wr_i;
        end
        if (y_we) begin
            y_r_mem[y_cnt] <= y_wr_r;
            y_i_mem[y_cnt] <= y_conj_i;
        end
    end

    assign h_rd_addr = HW'(int'(rd_h_row) * NT + int'(rd_h_col));
    assign y_rd_addr = YW'(int'(rd_y_slot) * NR + int'(rd_y_idx));

    assign rd_h_r = h_r_mem[h_rd_addr];
    assign rd_h_i = h_i_mem[h_rd_addr];
    assign rd_y_r = y_r_mem[y_rd_addr];
    assign rd_y_i = y_i_mem[y_rd_addr];

endmodule

// File: rtl/hy_pingpong_loader.sv
// Two-bank H/Y loader: fill-side bank arbitration plus the calc FSM that runs
// NUM_Q q passes over the calc bank while the other bank fills.
//
// state     | meaning
// C_IDLE    | waiting for a full bank to process
// C_START   | q_start pulse for pass q_index
// C_WAIT    | waiting for q_done from the datapath
// C_RELEASE | frame_done pulse, calc bank handed back to fill side
module hy_pingpong_loader
    import hy_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int NR    = 4,
    parameter int NT    = 4,
    parameter int NSLOT = 2,
    parameter int NUM_Q = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h_in_valid,
    output logic                      h_in_ready,
    input  logic [N-1:0]              h_in_r,
    input  logic [N-1:0]              h_in_i,
    input  logic                      y_in_valid,
    output logic                      y_in_ready,
    input  logic [N-1:0]              y_in_r,
    input  logic [N-1:0]              y_in_i,
    input  logic [idx_w(NR)-1:0]      rd_h_row,
    input  logic [idx_w(NT)-1:0]      rd_h_col,
    output logic [N-1:0]              rd_h_r,
    output logic [N-1:0]              rd_h_i,
    input  logic [idx_w(NR)-1:0]      rd_y_idx,
    input  logic [idx_w(NSLOT)-1:0]   rd_y_slot,
    output logic [N-1:0]              rd_y_r,
    output logic [N-1:0]              rd_y_i,
    output logic                      q_start,
    output logic [idx_w(NUM_Q)-1:0]   q_index,
    input  logic                      q_done,
    output logic                      frame_done,
    output logic                      calc_bank,
    output logic                      busy,
    output logic                      proto_err
);

    localparam int QW = idx_w(NUM_Q);
    localparam logic [QW-1:0] Q_LAST = QW'(NUM_Q - 1);

    calc_state_t state;
    logic        fill_bank;
    logic        other_bank;
    logic        release_now;
    logic        fill_full_eff;
    logic        other_free;

    logic [NUM_BANKS-1:0] bank_h_we;
    logic [NUM_BANKS-1:0] bank_y_we;
    logic [NUM_BANKS-1:0] bank_rel;
    logic [NUM_BANKS-1:0] bank_h_done;
    logic [NUM_BANKS-1:0] bank_y_done;
    logic [NUM_BANKS-1:0] bank_full;
    logic [NUM_BANKS-1:0] bank_complete;
    logic [N-1:0]         bank_h_r [NUM_BANKS];
    logic [N-1:0]         bank_h_i [NUM_BANKS];
    logic [N-1:0]         bank_y_r [NUM_BANKS];
    logic [N-1:0]         bank_y_i [NUM_BANKS];

    assign other_bank  = ~fill_bank;
    assign release_now = (state == C_RELEASE);
    assign h_in_ready  = !bank_h_done[fill_bank];
    assign y_in_ready  = !bank_y_done[fill_bank];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_h_we[b] = h_in_valid && h_in_ready && (fill_bank == 1'(b));
        assign bank_y_we[b] = y_in_valid && y_in_ready && (fill_bank == 1'(b));
        assign bank_rel[b]  = release_now && (calc_bank == 1'(b));

        hy_bank_mem #(
            .N     (N),
            .NR    (NR),
            .NT    (NT),
            .NSLOT (NSLOT)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .h_we      (bank_h_we[b]),
            .h_wr_r    (h_in_r),
            .h_wr_i    (h_in_i),
            .y_we      (bank_y_we[b]),
            .y_wr_r    (y_in_r),
            .y_wr_i    (y_in_i),
            .rel       (bank_rel[b]),
            .rd_h_row  (rd_h_row),
            .rd_h_col  (rd_h_col),
            .rd_y_idx  (rd_y_idx),
            .rd_y_slot (rd_y_slot),
            .rd_h_r    (bank_h_r[b]),
            .rd_h_i    (bank_h_i[b]),
            .rd_y_r    (bank_y_r[b]),
            .rd_y_i    (bank_y_i[b]),
            .h_done    (bank_h_done[b]),
            .y_done    (bank_y_done[b]),
            .full      (bank_full[b]),
            .complete  (bank_complete[b])
        );
    end

    assign rd_h_r = bank_h_r[calc_bank];
    assign rd_h_i = bank_h_i[calc_bank];
    assign rd_y_r = bank_y_r[calc_bank];
    assign rd_y_i = bank_y_i[calc_bank];

    // Looking at this cycle's completion and release lets a bank released in
    // the same cycle that the fill bank completes become the new fill bank.
    assign fill_full_eff = bank_full[fill_bank] || bank_complete[fill_bank];
    assign other_free    = !bank_full[other_bank] || bank_rel[other_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_bank <= 1'b0;
        end else if (fill_full_eff && other_free) begin
            fill_bank <= other_bank;
        end
    end

    // The fill pointer always moves off a full bank when it can, so a bank
    // waiting for calc is always the one opposite the fill bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= C_IDLE;
            calc_bank  <= 1'b0;
            q_index    <= '0;
            q_start    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            q_start    <= 1'b0;
            frame_done <= 1'b0;
            if (q_done && (state != C_WAIT)) begin
                proto_err <= 1'b1;
            end
            case (state)
                C_IDLE: begin
                    if (bank_full[other_bank]) begin
                        calc_bank <= other_bank;
                        q_index   <= '0;
                        q_start   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= C_START;
                    end
                end
                C_START: begin
                    state <= C_WAIT;
                end
                C_WAIT: begin
                    if (q_done) begin
                        if (q_index == Q_LAST) begin
                            frame_done <= 1'b1;
                            state      <= C_RELEASE;
                        end else begin
                            q_index <= q_index + QW'(1);
                            q_start <= 1'b1;
                            state   <= C_START;
                        end
                    end
                end
                C_RELEASE: begin
                    busy  <= 1'b0;
                    state <= C_IDLE;
                end
                default: begin
                    state <= C_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hy_pingpong_loader.sv
// Scoreboard bench for hy_pingpong_loader: random frames are queued as they
// load; a monitor checks every pass, the calc-bank contents and frame_done.
`timescale 1ns/1ps
module tb_hy_pingpong_loader;

    localparam int N     = 32;
    localparam int NR    = 4;
    localparam int NT    = 4;
    localparam int NSLOT = 2;
    localparam int NUM_Q = 16;
    localparam int HD    = NR * NT;
    localparam int YD    = NR * NSLOT;
    localparam int MF    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         h_in_valid = 1'b0, y_in_valid = 1'b0;
    logic         h_in_ready, y_in_ready;
    logic [N-1:0] h_in_r = '0, h_in_i = '0, y_in_r = '0, y_in_i = '0;
    logic [1:0]   rd_h_row = '0, rd_h_col = '0, rd_y_idx = '0;
    logic         rd_y_slot = 1'b0;
    logic [N-1:0] rd_h_r, rd_h_i, rd_y_r, rd_y_i;
    logic         q_start, q_done, frame_done, calc_bank, busy, proto_err;
    logic [3:0]   q_index;
    logic         resp_qdone = 1'b0, inj_qdone = 1'b0;
    logic         hold_q = 1'b0, stall_chk = 1'b0;

    int total = 0;
    int bad = 0;
    int loaded = 0;
    int done_frames = 0;
    int sb_q[$];
    logic [N-1:0] m_hr [MF][HD];
    logic [N-1:0] m_hi [MF][HD];
    logic [N-1:0] m_yr [MF][YD];
    logic [N-1:0] m_yi [MF][YD];

    always #5 clk = ~clk;
    assign q_done = resp_qdone | inj_qdone;

    hy_pingpong_loader #(.N(N), .NR(NR), .NT(NT), .NSLOT(NSLOT), .NUM_Q(NUM_Q)) dut (
        .clk(clk), .rst(rst),
        .h_in_valid(h_in_valid), .h_in_ready(h_in_ready), .h_in_r(h_in_r), .h_in_i(h_in_i),
        .y_in_valid(y_in_valid), .y_in_ready(y_in_ready), .y_in_r(y_in_r), .y_in_i(y_in_i),
        .rd_h_row(rd_h_row), .rd_h_col(rd_h_col), .rd_h_r(rd_h_r), .rd_h_i(rd_h_i),
        .rd_y_idx(rd_y_idx), .rd_y_slot(rd_y_slot), .rd_y_r(rd_y_r), .rd_y_i(rd_y_i),
        .q_start(q_start), .q_index(q_index), .q_done(q_done), .frame_done(frame_done),
        .calc_bank(calc_bank), .busy(busy), .proto_err(proto_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stored Y imag is the arithmetic negation, clamped to the positive range.
    function automatic logic [N-1:0] conj_i(input logic [N-1:0] v);
        longint x;
        longint max_v;
        max_v = (longint'(1) <<< (N - 1)) - 1;
        x = -longint'($signed(v));
        if (x > max_v) x = max_v;
        return x[N-1:0];
    endfunction

    task automatic load_frame(output int stalls);
        int id;
        int hk;
        int yk;
        int cyc;
        id = loaded % MF;
        hk = 0; yk = 0; cyc = 0; stalls = 0;
        for (int k = 0; k < HD; k++) begin
            m_hr[id][k] = $urandom;
            m_hi[id][k] = $urandom;
        end
        for (int k = 0; k < YD; k++) begin
            m_yr[id][k] = $urandom;
            m_yi[id][k] = $urandom;
        end
        if (loaded == 0) begin
            m_yi[id][0] = 32'h0000_0010;
            m_hr[id][2*NT+3] = 32'h1234_5678;
        end
        if (loaded == 3) m_yi[id][5] = 32'h8000_0000;
        while ((hk < HD || yk < YD) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            h_in_valid = (hk < HD) && ($urandom_range(0, 3) != 0);
            y_in_valid = (yk < YD) && ($urandom_range(0, 3) != 0);
            h_in_r = m_hr[id][hk % HD];
            h_in_i = m_hi[id][hk % HD];
            y_in_r = m_yr[id][yk % YD];
            y_in_i = m_yi[id][yk % YD];
            if ((h_in_valid && !h_in_ready) || (y_in_valid && !y_in_ready)) stalls++;
            if (h_in_valid && h_in_ready) hk++;
            if (y_in_valid && y_in_ready) yk++;
        end
        @(negedge clk);
        h_in_valid = 1'b0;
        y_in_valid = 1'b0;
        check("load_beats", 64'(hk * 100 + yk), 64'(HD * 100 + YD));
        sb_q.push_back(loaded);
        loaded++;
    endtask

    task automatic wait_all();
        int cyc;
        cyc = 0;
        while (done_frames != loaded && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("all_frames_done", 64'(done_frames), 64'(loaded));
        @(negedge clk);
        check("idle_after_frames", 64'({busy, proto_err}), 64'(2'b00));
    endtask

    task automatic check_reset_vals();
        check("reset_outputs",
              64'({q_start, frame_done, busy, proto_err, calc_bank, h_in_ready, y_in_ready}),
              64'(7'b0000011));
        check("reset_q_index", 64'(q_index), 64'(0));
    endtask

    // Monitor and datapath responder.
    initial begin : monitor
        int cur;
        int passes;
        int dly;
        int e;
        bit active;
        bit pend;
        bit chk_ready_next;
        cur = 0; passes = 0; dly = 0; active = 0; pend = 0; chk_ready_next = 0;
        forever begin
            @(negedge clk);
            resp_qdone = 1'b0;
            if (rst) begin
                active = 0; pend = 0; chk_ready_next = 0; done_frames = 0;
                sb_q.delete();
                continue;
            end
            if (chk_ready_next) begin
                check("ready_after_release", 64'({h_in_ready, y_in_ready}), 64'(2'b11));
                chk_ready_next = 0;
            end
            if (pend && !hold_q) begin
                if (dly == 0) begin
                    resp_qdone = 1'b1;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            if (active && !q_start && !frame_done)
                check("q_index_hold", 64'(q_index), 64'(passes - 1));
            if (q_start) begin
                if (!active) begin
                    check("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
                    if (sb_q.size() > 0) cur = sb_q.pop_front();
                    active = 1;
                    passes = 0;
                end
                check("q_index", 64'(q_index), 64'(passes));
                check("calc_bank", 64'(calc_bank), 64'(cur % 2));
                check("busy_in_pass", 64'(busy), 64'(1));
                e = passes % YD;
                rd_h_row  = 2'((passes % HD) / NT);
                rd_h_col  = 2'((passes % HD) % NT);
                rd_y_slot = 1'(e / NR);
                rd_y_idx  = 2'(e % NR);
                #1;
                check("rd_h_r", 64'(rd_h_r), 64'(m_hr[cur % MF][passes % HD]));
                check("rd_h_i", 64'(rd_h_i), 64'(m_hi[cur % MF][passes % HD]));
                check("rd_y_r", 64'(rd_y_r), 64'(m_yr[cur % MF][e]));
                check("rd_y_i", 64'(rd_y_i), 64'(conj_i(m_yi[cur % MF][e])));
                passes++;
                pend = 1;
                dly = $urandom_range(0, 3);
            end
            if (frame_done) begin
                check("frame_passes", 64'(active ? passes : 0), 64'(NUM_Q));
                active = 0;
                done_frames++;
                if (stall_chk) chk_ready_next = 1;
            end
        end
    end

    initial begin : main
        int st;
        int st2;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        loaded = 0;
        rst = 1'b0;
        @(negedge clk);

        // Single frame, including the two-cycle q_start latency.
        load_frame(st);
        check("t1_no_stall", 64'(st), 64'(0));
        check("t1_lat_c1", 64'(q_start), 64'(0));
        @(negedge clk);
        check("t1_lat_c2", 64'(q_start), 64'(1));
        wait_all();
        check("t1_calc_bank", 64'(calc_bank), 64'(0));

        // Back-to-back frames: second loads while first is calculating.
        load_frame(st);
        load_frame(st2);
        check("t2_second_no_stall", 64'(st2), 64'(0));
        wait_all();

        // Three frames with q_done withheld: fill stalls until a release.
        hold_q = 1'b1;
        load_frame(st);
        load_frame(st);
        repeat (5) @(negedge clk);
        check("t3_both_ready_low", 64'({h_in_ready, y_in_ready}), 64'(2'b00));
        fork
            load_frame(st2);
            begin
                repeat (30) @(negedge clk);
                check("t3_still_stalled", 64'({h_in_ready, y_in_ready}), 64'(2'b00));
                stall_chk = 1'b1;
                hold_q = 1'b0;
            end
        join
        stall_chk = 1'b0;
        check("t3_third_stalled", 64'(st2 > 0), 64'(1));
        wait_all();

        // q_done while idle is a protocol error and changes nothing else.
        @(negedge clk);
        inj_qdone = 1'b1;
        @(negedge clk);
        inj_qdone = 1'b0;
        check("proto_err_set", 64'(proto_err), 64'(1));
        check("proto_q_index", 64'(q_index), 64'(NUM_Q - 1));
        repeat (10) @(negedge clk);
        check("proto_err_sticky", 64'({proto_err, busy}), 64'(2'b10));

        // Reset in the middle of an H load, then a clean frame from bank 0.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            h_in_valid = 1'b1;
            h_in_r = $urandom;
            h_in_i = $urandom;
        end
        @(negedge clk);
        h_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        loaded = 0;
        rst = 1'b0;
        @(negedge clk);
        load_frame(st);
        check("t6_no_stall", 64'(st), 64'(0));
        wait_all();
        check("t6_calc_bank", 64'(calc_bank), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hy_pingpong_loader.md
Name: hy_pingpong_loader

Overview:
Parametrised successor to the single-bank H/Y load-then-calculate controller of the spatial-modulation detector. It accepts streamed channel matrix H (NR x NT complex) and received vectors Y (NR x NSLOT complex, conjugated on write) into two ping-pong banks. It then sequences NUM_Q candidate-index passes (q_start/q_done handshake) over the calc bank while the next frame loads into the other bank. It sits between the frame input interface and the Hq/G/trace/x datapath.

Parameters:
N, 32, sample word width (signed fixed point, both real and imaginary parts)
NR, 4, receive antennas (H rows, Y entries per slot)
NT, 4, transmit antennas (H columns)
NSLOT, 2, Y time slots per frame
NUM_Q, 16, q passes per frame; q_index counts 0..NUM_Q-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
h_in_valid  in  1  H beat valid
h_in_ready  out  1  H beat accepted when valid&&ready
h_in_r, h_in_i  in  N each  H element, row-major
y_in_valid  in  1  Y beat valid
y_in_ready  out  1  Y beat accepted when valid&&ready
y_in_r, y_in_i  in  N each  Y element, slot-major
rd_h_row  in  clog2(NR)  calc-bank H read row
rd_h_col  in  clog2(NT)  calc-bank H read column
rd_h_r, rd_h_i  out  N each  combinational H read data
rd_y_idx  in  clog2(NR)  calc-bank Y read entry
rd_y_slot  in  clog2(NSLOT)  calc-bank Y read slot
rd_y_r, rd_y_i  out  N each  combinational Y read data (already conjugated)
q_start  out  1  one-cycle pulse starting pass q_index
q_index  out  clog2(NUM_Q)  current pass index, stable from q_start until q_done
q_done  in  1  datapath finished current pass
frame_done  out  1  one-cycle pulse after the last pass of a frame
calc_bank  out  1  bank index currently read by datapath
busy  out  1  calc FSM not in C_IDLE
proto_err  out  1  sticky; set by q_done outside C_WAIT; cleared only by rst

Behaviour:
- Reset (async): both banks empty, fill bank=0, calc_bank=0. q_start, frame_done, busy, proto_err=0. q_index=0. Both ready outputs=1. Bank RAM contents are not reset.
- Reset mid-operation aborts any load or pass immediately. Partially loaded data is discarded (counters to 0).
- Fill side, per bank: independent H counter (0..NR*NT-1) and Y counter (0..NR*NSLOT-1).
- H beat k goes to row k/NT, column k%NT. Y beat k goes to slot k/NR, entry k%NR.
- y_in_i is stored negated. Saturation: -2^(N-1) stores as 2^(N-1)-1.
- h_in_ready=1 while the fill bank is not full and its H counter has not wrapped. Same rule for y_in_ready with the Y counter. H and Y may interleave in any order, including the same cycle.
- The fill bank becomes full at the edge that accepts the later of the last H beat and the last Y beat. Fill then toggles to the other bank if that bank is empty. Otherwise both ready outputs stay 0 until a bank is released.
- Calc FSM states: C_IDLE, C_START, C_WAIT, C_RELEASE.
  - C_IDLE: if a full bank not in use exists, latch calc_bank, q_index=0, go to C_START.
  - C_START: q_start=1 for exactly one cycle, then C_WAIT.
  - C_WAIT: on q_done, if q_index==NUM_Q-1 go to C_RELEASE; else q_index+1 and go to C_START.
  - C_RELEASE: frame_done=1 for one cycle, mark calc_bank empty, go to C_IDLE.
- Latency: q_start is high during the 2nd cycle after the cycle in which the completing beat is accepted, when the calc FSM is idle.
- Bank release and a fill completion in the same cycle: the released bank becomes the new fill bank, and the completed bank is taken by C_IDLE on the next cycle. No stall, no lost beat.
- q_done in C_IDLE, C_START or C_RELEASE: ignored, sets proto_err.
- Read ports always address the calc bank. Reads are defined only while busy.

Decomposition:
- Package hy_loader_pkg: calc state encodings, NUM_BANKS=2, and a width helper for clog2 index widths.
- Sub-module hy_bank_mem (one bank: H/Y arrays, write counters, full flag, conjugate/saturate logic, read mux), instantiated twice.
- The top level holds fill/calc arbitration and the calc FSM.

Test Plan:
- Single frame, NR=NT=4, NSLOT=2: 16 H + 8 Y beats. Y beat 0 imag=0x00000010 reads back 0xFFFFFFF0 at (idx0, slot0). Q passes 0..15 each need one q_done. frame_done pulses once. calc_bank=0.
- Back-to-back frames: load frame 2 while frame 1 passes run. Frame 2 loads fully with ready=1. Its first q_start follows frame 1's frame_done, with calc_bank=1 and q_index=0.
- Three frames, no q_done: after two full banks, both ready outputs=0. They rise the cycle after frame_done; no beat is dropped.
- Y imag = 0x80000000 stores as 0x7FFFFFFF. H beat (row2, col3) value 0x12345678 reads back at rd_h_row=2, rd_h_col=3.
- q_done pulsed in C_IDLE: proto_err=1 and stays 1. q_index is unaffected.
- rst asserted after 10 H beats mid-frame: outputs return to reset values asynchronously. A fresh full frame then completes normally from bank 0.
